// File: rtl/data_buff_rd_ctrl.sv
// rtl/data_buff_rd_ctrl.sv - read sequencer from column buffer FIFO to PE array
// Streams kernel_size^2 elements per window through a 2-entry skid, tagging window boundaries.
module data_buff_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            kernel_size,
    input  logic [CNT_WIDTH-1:0]  num_windows,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] pe_data,
    output logic                  PE_VALID,
    input  logic                  PE_READY,
    output logic                  pe_first,
    output logic                  pe_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

    state_t                  state_q;
    logic                    busy_q, done_q;
    logic [CNT_WIDTH-1:0]    total_q, nwin_q;
    logic [CNT_WIDTH-1:0]    rd_elem_q, rd_win_q, out_elem_q, out_win_q;
    logic [1:0]              skid_cnt_q;
    logic                    rd_pend_q;
    logic [DATA_WIDTH-1:0]   skid0_q, skid1_q;

    logic [15:0]             ks_sq;
    logic [2:0]              inflight;
    logic                    accept, rd_room, last_rd, out_last_elem, job_last_acc, job_ok;

    assign ks_sq         = {8'd0, kernel_size} * {8'd0, kernel_size};
    assign job_ok        = (kernel_size != 8'd0) && (num_windows != '0);
    assign PE_VALID      = (skid_cnt_q != 2'd0);
    assign pe_data       = skid0_q;
    assign accept        = PE_VALID & PE_READY;
    // Entries already held or on their way from the FIFO must leave room for the new read.
    assign inflight      = {1'b0, skid_cnt_q} + {2'b0, rd_pend_q};
    assign rd_room       = inflight < (3'd2 + {2'b0, accept});
    assign fifo_rd_en    = (state_q == STREAM) & ~fifo_empty & rd_room;
    assign last_rd       = (rd_win_q == nwin_q - 1'b1) && (rd_elem_q == total_q - 1'b1);
    assign out_last_elem = (out_elem_q == total_q - 1'b1);
    assign job_last_acc  = accept & out_last_elem & (out_win_q == nwin_q - 1'b1);
    assign pe_first      = PE_VALID & (out_elem_q == '0);
    assign pe_last       = PE_VALID & out_last_elem;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            total_q <= '0;
            nwin_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        total_q <= CNT_WIDTH'(ks_sq);
                        nwin_q  <= num_windows;
                        if (job_ok) begin
                            state_q <= STREAM;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (fifo_rd_en && last_rd) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (job_last_acc) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_elem_q  <= '0;
            rd_win_q   <= '0;
            out_elem_q <= '0;
            out_win_q  <= '0;
        end else if (state_q == IDLE) begin
            rd_elem_q  <= '0;
            rd_win_q   <= '0;
            out_elem_q <= '0;
            out_win_q  <= '0;
        end else begin
            if (fifo_rd_en) begin
                if (rd_elem_q == total_q - 1'b1) begin
                    rd_elem_q <= '0;
                    rd_win_q  <= rd_win_q + 1'b1;
                end else begin
                    rd_elem_q <= rd_elem_q + 1'b1;
                end
            end
            if (accept) begin
                if (out_last_elem) begin
                    out_elem_q <= '0;
                    out_win_q  <= out_win_q + 1'b1;
                end else begin
                    out_elem_q <= out_elem_q + 1'b1;
                end
            end
        end
    end

    // Skid entry 0 is always the head; pops shift entry 1 forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            rd_pend_q <= fifo_rd_en;
            case ({rd_pend_q, accept})
                2'b10: begin
                    if (skid_cnt_q == 2'd0) skid0_q <= fifo_rdata;
                    else                    skid1_q <= fifo_rdata;
                    skid_cnt_q <= skid_cnt_q + 2'd1;
                end
                2'b01: begin
                    skid0_q    <= skid1_q;
                    skid_cnt_q <= skid_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_q == 2'd1) begin
                        skid0_q <= fifo_rdata;
                    end else begin
                        skid0_q <= skid1_q;
                        skid1_q <= fifo_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_pend_q && !accept && skid_cnt_q == 2'd2));

endmodule

// File: tb/tb_data_buff_rd_ctrl.sv
// tb/tb_data_buff_rd_ctrl.sv - directed self-checking bench for data_buff_rd_ctrl
module tb_data_buff_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  kernel_size;
    logic [15:0] num_windows;
    logic        fifo_empty;
    logic [15:0] fifo_rdata = 16'd0;
    logic        fifo_rd_en;
    logic [15:0] pe_data;
    logic        PE_VALID;
    logic        PE_READY;
    logic        pe_first;
    logic        pe_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    int cyc = 0, start_cyc = 0, rptr = 0, base = 0;
    logic force_empty = 1'b0;
    int rd_cnt, acc_cnt, valid_cnt, busy_seen, done_cnt, rd_in_stall;
    int first_rd, first_valid, last_acc, done_cyc, abort_base;
    logic [15:0] q_data[$];
    bit          q_first[$];
    bit          q_last[$];
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    bit          prev_first, prev_last;

    data_buff_rd_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
        .num_windows(num_windows), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .pe_data(pe_data), .PE_VALID(PE_VALID),
        .PE_READY(PE_READY), .pe_first(pe_first), .pe_last(pe_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // FIFO holds word i at address i; one-cycle read latency.
    assign fifo_empty = force_empty | (rptr >= 1000);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            fifo_rdata <= 16'(rptr);
            rptr       <= rptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", PE_VALID, 1);
                chk("hold_data", pe_data, prev_data);
                chk("hold_flags", {pe_first, pe_last}, {prev_first, prev_last});
            end
            if (!PE_VALID) chk("flags_idle", {pe_first, pe_last}, 0);
            if (fifo_rd_en) begin
                chk("credit", ((rd_cnt - acc_cnt - int'(PE_VALID & PE_READY)) < 2), 1);
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc - start_cyc;
                if (force_empty) rd_in_stall++;
            end
            if (PE_VALID) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc - start_cyc;
            end
            if (PE_VALID && PE_READY) begin
                q_data.push_back(pe_data);
                q_first.push_back(pe_first);
                q_last.push_back(pe_last);
                acc_cnt++;
                last_acc = cyc - start_cyc;
            end
            if (busy) busy_seen++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
            end
            prev_stall = PE_VALID & ~PE_READY;
            prev_data  = pe_data;
            prev_first = pe_first;
            prev_last  = pe_last;
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_job(input int ks, input int nw, input int mode,
                           input int stall_after, input int restart_at, input int abort_at);
        int k, stall_left, post;
        bit stalled;
        q_data.delete(); q_first.delete(); q_last.delete();
        rd_cnt = 0; acc_cnt = 0; valid_cnt = 0; busy_seen = 0; done_cnt = 0; rd_in_stall = 0;
        first_rd = -1; first_valid = -1; last_acc = -1; done_cyc = -1;
        base = rptr;
        kernel_size = 8'(ks);
        num_windows = 16'(nw);
        start = 1'b1;
        start_cyc = cyc;
        PE_READY = ready_for(mode, 0);
        k = 0; stall_left = 0; stalled = 0; post = 0;
        while (k < 400) begin
            @(posedge clk); #2;
            k++;
            start = (k == restart_at);
            PE_READY = ready_for(mode, k);
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) force_empty = 1'b0;
            end else if (!stalled && stall_after >= 0 && rd_cnt >= stall_after) begin
                force_empty = 1'b1;
                stall_left = 5;
                stalled = 1;
            end
            if (k == abort_at) break;
            if (done_cnt > 0) post++;
            if (post >= 4) break;
        end
        start = 1'b0;
        chk("job_timeout", (k >= 400), 0);
    endtask

    task automatic verify_stream(input string tag, input int n, input int total);
        chk({tag, "_count"}, q_data.size(), n);
        for (int i = 0; i < q_data.size() && i < n; i++) begin
            chk({tag, "_data"}, q_data[i], 16'(base + i));
            chk({tag, "_first"}, q_first[i], (i % total) == 0);
            chk({tag, "_last"}, q_last[i], (i % total) == total - 1);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pe"}, {PE_VALID, pe_data, pe_first, pe_last}, 0);
        chk({tag, "_ctl"}, {fifo_rd_en, busy, done}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kernel_size = 8'd0; num_windows = 16'd0; PE_READY = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk); #2;

        run_job(3, 2, 0, -1, -1, -1);
        verify_stream("full_rate", 18, 9);
        chk("first_rd_cyc", first_rd, 1);
        chk("first_valid_cyc", first_valid, 3);
        chk("back_to_back", last_acc - first_valid, 17);
        chk("done_after_last", done_cyc, last_acc + 1);
        chk("busy_full_rate", busy_seen > 0, 1);

        run_job(3, 2, 1, -1, -1, -1);
        verify_stream("ready_toggle", 18, 9);

        run_job(3, 2, 0, 4, -1, -1);
        verify_stream("empty_stall", 18, 9);
        chk("rd_during_empty", rd_in_stall, 0);

        run_job(0, 2, 0, -1, -1, -1);
        chk("ks0_reads", rd_cnt, 0);
        chk("ks0_valid", valid_cnt, 0);
        chk("ks0_busy", busy_seen, 0);
        chk("ks0_done_cnt", done_cnt, 1);
        chk("ks0_done_cyc", (done_cyc >= 1 && done_cyc <= 2), 1);

        run_job(3, 0, 0, -1, -1, -1);
        chk("nw0_reads", rd_cnt, 0);
        chk("nw0_valid", valid_cnt, 0);
        chk("nw0_busy", busy_seen, 0);
        chk("nw0_done_cnt", done_cnt, 1);

        run_job(1, 3, 0, -1, 2, -1);
        verify_stream("ks1", 3, 1);
        chk("ks1_reads", rd_cnt, 3);

        run_job(3, 2, 2, -1, -1, 5);
        chk("abort_inflight", rd_cnt, 2);
        abort_base = base;
        rst = 1'b1;
        #1;
        chk_idle("mid_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        run_job(3, 2, 0, -1, -1, -1);
        chk("restart_base", base, abort_base + 2);
        verify_stream("restart", 18, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
